fp_addsub: RTL and testbench

FP_ADDSUB -- requirements
Module: fp_addsub

---
 rtl/fp_addsub.sv | 147 ++++++++++++++
 tb/tb_fp_addsub.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub.sv
// fp_addsub: multi-cycle floating-point adder/subtractor with five rounding modes and exception flags.
// Operands are unpacked, aligned, added, normalised and rounded one stage per cycle.
module fp_addsub #(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23,
  localparam int W = 1 + EXP_W + FRAC_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         data_ready_i,
  input  logic         op_sub_i,
  input  logic [2:0]   rounding_mode_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic         busy_o,
  output logic         data_valid_o,
  output logic [W-1:0] z_o,
  output logic         except_invalid_operation_o,
  output logic         except_overflow_o,
  output logic         except_underflow_o,
  output logic         except_inexact_o
);
  localparam int M = FRAC_W + 1;
  localparam int D = FRAC_W + 4;
  localparam int LW = $clog2(D + 1) + 1;
  localparam int EW = (EXP_W + 2 > LW) ? EXP_W + 2 : LW;
  localparam logic [EXP_W-1:0] E_MAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, E_MAX, 1'b1, {(FRAC_W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORMALIZE, ROUND, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] x_q, y_q;
  logic sub_q;
  logic [2:0] rm_q;
  logic sign_l, eff_sub;
  logic [EW-1:0] exp_l, exp_s, e_q;
  logic [M-1:0] sig_l, sig_s;
  logic [D-1:0] a_l, a_s, n_q;
  logic [D:0] sum;
  logic xs, ys, x_big, x_nan, y_nan, x_inf, y_inf, special, spec_nan, spec_inv;
  logic [EXP_W-1:0] xe, ye;
  logic [FRAC_W-1:0] xf, yf;
  logic [EW-1:0] xe_eff, ye_eff;
  logic [W-1:0] spec_z;
  assign {xs, xe, xf} = x_q;
  assign ye = y_q[W-2:FRAC_W];
  assign yf = y_q[FRAC_W-1:0];
  assign ys = y_q[W-1] ^ sub_q;
  assign x_big = x_q[W-2:0] >= y_q[W-2:0];
  assign x_nan = xe == E_MAX && xf != '0;
  assign y_nan = ye == E_MAX && yf != '0;
  assign x_inf = xe == E_MAX && xf == '0;
  assign y_inf = ye == E_MAX && yf == '0;
  assign special = xe == E_MAX || ye == E_MAX;
  assign spec_nan = x_nan | y_nan | (x_inf & y_inf & (xs ^ ys));
  assign spec_inv = (x_nan & ~xf[FRAC_W-1]) | (y_nan & ~yf[FRAC_W-1]) | (x_inf & y_inf & (xs ^ ys));
  assign spec_z = spec_nan ? QNAN : x_inf ? {xs, xe, xf} : {ys, ye, yf};
  assign xe_eff = xe == '0 ? EW'(1) : EW'(xe);
  assign ye_eff = ye == '0 ? EW'(1) : EW'(ye);
  // alignment: bits pushed past the datapath collapse into the sticky bit
  logic [EW-1:0] diff;
  logic [D-1:0] full_s, shr_s, lost, a_s_n;
  assign diff = exp_l - exp_s;
  assign full_s = {sig_s, 3'b000};
  assign shr_s = full_s >> diff;
  assign lost = full_s & ~({D{1'b1}} << diff);
  assign a_s_n = diff > EW'(D - 1) ? {{(D-1){1'b0}}, |sig_s} : {shr_s[D-1:1], shr_s[0] | (|lost)};
  logic [EW-1:0] lz, sh;
  always_comb begin
    lz = EW'(D);
    for (int i = 0; i < D; i++) if (sum[i]) lz = EW'(D - 1 - i);
  end
  // left shift never takes the exponent below 1, leaving a subnormal instead
  assign sh = lz > exp_l - EW'(1) ? exp_l - EW'(1) : lz;
  logic g, r, s, lsb, inexact, inc, ovf, zero, to_inf, z_sign;
  logic [M:0] rnd;
  logic [EW-1:0] ef;
  logic [W-1:0] z_fin;
  assign {lsb, g, r, s} = n_q[3:0];
  assign inexact = g | r | s;
  assign inc = rm_q == 3'd1 ? 1'b0 :
               rm_q == 3'd2 ? sign_l & inexact :
               rm_q == 3'd3 ? ~sign_l & inexact :
               rm_q == 3'd4 ? g : g & (r | s | lsb);
  assign rnd = {1'b0, n_q[D-1:3]} + {{M{1'b0}}, inc};
  // a set hidden bit after rounding also promotes a subnormal to exponent 1
  assign ef = rnd[M] ? e_q + EW'(1) : rnd[M-1] ? e_q : '0;
  assign ovf = ef >= EW'(E_MAX);
  assign zero = rnd == '0;
  assign z_sign = zero ? (eff_sub ? rm_q == 3'd2 : sign_l) : sign_l;
  assign to_inf = rm_q == 3'd0 || rm_q == 3'd4 || (rm_q == 3'd3 && !sign_l) || (rm_q == 3'd2 && sign_l);
  assign z_fin = !ovf ? {z_sign, ef[EXP_W-1:0], rnd[FRAC_W-1:0]} :
                 to_inf ? {sign_l, E_MAX, {FRAC_W{1'b0}}} :
                 {sign_l, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = data_ready_i ? UNPACK : IDLE;
      UNPACK: state_n = special ? DONE : ALIGN;
      ALIGN: state_n = ADD;
      ADD: state_n = NORMALIZE;
      NORMALIZE: state_n = ROUND;
      ROUND: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  assign busy_o = state != IDLE;
  assign data_valid_o = state == DONE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      z_o <= '0;
      {except_invalid_operation_o, except_overflow_o, except_underflow_o, except_inexact_o} <= '0;
    end else begin
      if (state == IDLE && data_ready_i) begin
        x_q <= x_i;
        y_q <= y_i;
        sub_q <= op_sub_i;
        rm_q <= rounding_mode_i > 3'd4 ? 3'd0 : rounding_mode_i;
      end
      if (state == UNPACK) begin
        sign_l <= x_big ? xs : ys;
        eff_sub <= xs ^ ys;
        exp_l <= x_big ? xe_eff : ye_eff;
        exp_s <= x_big ? ye_eff : xe_eff;
        sig_l <= x_big ? {|xe, xf} : {|ye, yf};
        sig_s <= x_big ? {|ye, yf} : {|xe, xf};
        if (special) begin
          z_o <= spec_z;
          {except_invalid_operation_o, except_overflow_o, except_underflow_o, except_inexact_o} <= {spec_inv, 3'b000};
        end
      end
      if (state == ALIGN) begin
        a_l <= {sig_l, 3'b000};
        a_s <= a_s_n;
      end
      if (state == ADD) sum <= eff_sub ? {1'b0, a_l} - {1'b0, a_s} : {1'b0, a_l} + {1'b0, a_s};
      if (state == NORMALIZE) begin
        n_q <= sum[D] ? {sum[D:2], sum[1] | sum[0]} : sum[D-1:0] << sh;
        e_q <= sum[D] ? exp_l + EW'(1) : exp_l - sh;
      end
      if (state == ROUND) begin
        z_o <= z_fin;
        {except_invalid_operation_o, except_overflow_o, except_underflow_o, except_inexact_o} <= {1'b0, ovf, ef == '0 && inexact, inexact | ovf};
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub.sv
// tb_fp_addsub: directed vectors plus randomized operands checked against an exact-integer
// reference model of single-precision addition with all five rounding modes.
module tb_fp_addsub;
  logic clk_i = 1'b0;
  logic rst_i, data_ready_i, op_sub_i;
  logic [2:0] rounding_mode_i;
  logic [31:0] x_i, y_i, z_o;
  logic busy_o, data_valid_o;
  logic except_invalid_operation_o, except_overflow_o, except_underflow_o, except_inexact_o;
  int checks = 0;
  int errors = 0;
  fp_addsub #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .data_ready_i(data_ready_i),
    .op_sub_i(op_sub_i),
    .rounding_mode_i(rounding_mode_i),
    .x_i(x_i),
    .y_i(y_i),
    .busy_o(busy_o),
    .data_valid_o(data_valid_o),
    .z_o(z_o),
    .except_invalid_operation_o(except_invalid_operation_o),
    .except_overflow_o(except_overflow_o),
    .except_underflow_o(except_underflow_o),
    .except_inexact_o(except_inexact_o)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // value = sig * 2^(e-150); scaled by 2^149 every finite single is an exact integer
  task automatic model(input logic [31:0] x, input logic [31:0] y, input logic sub, input logic [2:0] rmi,
                       output logic [31:0] z, output logic [3:0] f);
    logic [299:0] xv, yv, mag, keep, rem, half;
    logic xs, ys, sg, inex, inc, xn, yn, xi, yi, to_inf;
    logic [2:0] rm;
    int xe, ye, p, e, sh, be;
    rm = rmi > 3'd4 ? 3'd0 : rmi;
    xs = x[31];
    ys = y[31] ^ sub;
    f = '0;
    if (&x[30:23] || &y[30:23]) begin
      xn = &x[30:23] && x[22:0] != 0;
      yn = &y[30:23] && y[22:0] != 0;
      xi = &x[30:23] && x[22:0] == 0;
      yi = &y[30:23] && y[22:0] == 0;
      if (xn || yn || (xi && yi && xs != ys)) begin
        z = 32'h7FC00000;
        f[3] = (xn && !x[22]) || (yn && !y[22]) || (xi && yi && xs != ys);
      end else z = xi ? x : {ys, y[30:0]};
    end else begin
      xe = x[30:23] == 0 ? 1 : int'(x[30:23]);
      ye = y[30:23] == 0 ? 1 : int'(y[30:23]);
      xv = 300'({x[30:23] != 0, x[22:0]}) << (xe - 1);
      yv = 300'({y[30:23] != 0, y[22:0]}) << (ye - 1);
      if (xs == ys) begin
        mag = xv + yv;
        sg = xs;
      end else if (xv >= yv) begin
        mag = xv - yv;
        sg = xs;
      end else begin
        mag = yv - xv;
        sg = ys;
      end
      if (mag == 0) z = {(xs == ys) ? xs : (rm == 3'd2), 31'd0};
      else begin
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22 < 1 ? 1 : p - 22;
        sh = e - 1;
        keep = mag >> sh;
        rem = mag - (keep << sh);
        half = sh == 0 ? 300'd0 : 300'd1 << (sh - 1);
        inex = rem != 0;
        inc = rm == 3'd1 ? 1'b0 :
              rm == 3'd2 ? sg && inex :
              rm == 3'd3 ? !sg && inex :
              rm == 3'd4 ? inex && rem >= half :
              rem > half || (inex && rem == half && keep[0]);
        keep = keep + 300'(inc);
        if (keep[24]) begin
          keep = keep >> 1;
          e++;
        end
        be = keep[23] ? e : 0;
        if (be >= 255) begin
          to_inf = rm == 3'd0 || rm == 3'd4 || (rm == 3'd3 && !sg) || (rm == 3'd2 && sg);
          z = to_inf ? {sg, 8'hFF, 23'd0} : {sg, 8'hFE, 23'h7FFFFF};
          f = 4'b0101;
        end else begin
          z = {sg, 8'(be), keep[22:0]};
          f = {2'b00, inex && be == 0, inex};
        end
      end
    end
  endtask
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sub, input logic [2:0] rm,
                        output logic [31:0] z, output logic [3:0] f, output int lat, output logic bz);
    x_i = x;
    y_i = y;
    op_sub_i = sub;
    rounding_mode_i = rm;
    data_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    data_ready_i = 1'b0;
    lat = -1;
    bz = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      bz &= busy_o;
      if (data_valid_o) begin
        lat = k;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    z = z_o;
    f = {except_invalid_operation_o, except_overflow_o, except_underflow_o, except_inexact_o};
    @(posedge clk_i);
    #1;
  endtask
  task automatic run_check(input string tag, input logic [31:0] x, input logic [31:0] y, input logic sub,
                           input logic [2:0] rm, input logic [31:0] ez, input logic [3:0] ef, input int el);
    logic [31:0] z;
    logic [3:0] f;
    int lat;
    logic bz;
    run_op(x, y, sub, rm, z, f, lat, bz);
    check({tag, " z"}, z, ez);
    check({tag, " flags"}, f, ef);
    check({tag, " latency"}, lat, el);
    check({tag, " busy"}, bz, 1);
    check({tag, " pulse"}, data_valid_o, 0);
  endtask
  initial begin
    logic [31:0] x, y, mz;
    logic [3:0] mf;
    logic sub;
    logic [2:0] rm;
    int c, pulses;
    rst_i = 1'b1;
    data_ready_i = 1'b0;
    op_sub_i = 1'b0;
    rounding_mode_i = 3'd0;
    x_i = '0;
    y_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("reset busy", busy_o, 0);
    check("reset valid", data_valid_o, 0);
    check("reset z", z_o, 0);
    check("reset flags", {except_invalid_operation_o, except_overflow_o, except_underflow_o, except_inexact_o}, 0);
    run_check("one_plus_one", 32'h3F800000, 32'h3F800000, 0, 3'd0, 32'h40000000, 4'b0000, 5);
    run_check("ulp_rne", 32'h3F800000, 32'h33800000, 0, 3'd0, 32'h3F800000, 4'b0001, 5);
    run_check("ulp_rup", 32'h3F800000, 32'h33800000, 0, 3'd3, 32'h3F800001, 4'b0001, 5);
    run_check("ulp_rtz", 32'h3F800000, 32'h33800000, 0, 3'd1, 32'h3F800000, 4'b0001, 5);
    run_check("ulp_rm7", 32'h3F800000, 32'h33800000, 0, 3'd7, 32'h3F800000, 4'b0001, 5);
    run_check("ovf_rne", 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 3'd0, 32'h7F800000, 4'b0101, 5);
    run_check("ovf_rtz", 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 3'd1, 32'h7F7FFFFF, 4'b0101, 5);
    run_check("ovf_rup_neg", 32'hFF7FFFFF, 32'hFF7FFFFF, 0, 3'd3, 32'hFF7FFFFF, 4'b0101, 5);
    run_check("ovf_rdn_neg", 32'hFF7FFFFF, 32'hFF7FFFFF, 0, 3'd2, 32'hFF800000, 4'b0101, 5);
    run_check("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1, 3'd0, 32'h7FC00000, 4'b1000, 1);
    run_check("qnan", 32'h7FC00000, 32'h3F800000, 0, 3'd0, 32'h7FC00000, 4'b0000, 1);
    run_check("snan", 32'h3F800000, 32'h7F800001, 0, 3'd0, 32'h7FC00000, 4'b1000, 1);
    run_check("neg_inf", 32'hFF800000, 32'h3F800000, 0, 3'd0, 32'hFF800000, 4'b0000, 1);
    run_check("cancel_rne", 32'h3F800000, 32'h3F800000, 1, 3'd0, 32'h00000000, 4'b0000, 5);
    run_check("cancel_rdn", 32'h3F800000, 32'h3F800000, 1, 3'd2, 32'h80000000, 4'b0000, 5);
    run_check("to_subnormal", 32'h00800000, 32'h00400000, 1, 3'd0, 32'h00400000, 4'b0000, 5);
    run_check("negzero_rup", 32'h80000000, 32'h80000000, 0, 3'd3, 32'h80000000, 4'b0000, 5);
    run_check("negzero_sub", 32'h80000000, 32'h00000000, 1, 3'd0, 32'h80000000, 4'b0000, 5);
    run_check("before_rst", 32'h3FC00000, 32'h3FC00000, 0, 3'd0, 32'h40400000, 4'b0000, 5);
    // reset asserted at the edge where the operation sits in ALIGN
    x_i = 32'h3F800000;
    y_i = 32'h3F800000;
    op_sub_i = 1'b0;
    rounding_mode_i = 3'd0;
    data_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    data_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("midrst busy", busy_o, 0);
    check("midrst z", z_o, 0);
    check("midrst flags", {except_invalid_operation_o, except_overflow_o, except_underflow_o, except_inexact_o}, 0);
    pulses = 0;
    repeat (8) begin
      @(posedge clk_i);
      #1;
      pulses += int'(data_valid_o);
    end
    check("midrst no pulse", pulses, 0);
    run_check("after_rst", 32'h3F800000, 32'h3F800000, 0, 3'd0, 32'h40000000, 4'b0000, 5);
    // start strobe held high throughout the operation
    x_i = 32'h3F800000;
    y_i = 32'h33800000;
    op_sub_i = 1'b0;
    rounding_mode_i = 3'd3;
    data_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      if (data_valid_o) begin
        pulses++;
        data_ready_i = 1'b0;
        check("hold z", z_o, 32'h3F800001);
      end
      @(posedge clk_i);
      #1;
    end
    data_ready_i = 1'b0;
    check("hold pulses", pulses, 1);
    check("hold idle", busy_o, 0);
    for (int n = 0; n < 400; n++) begin
      c = $urandom_range(0, 15);
      x = $urandom;
      y = $urandom;
      if (c < 6) y[30:23] = x[30:23] + 8'($urandom_range(0, 2)) - 8'd1;
      if (c == 6) y = x ^ 32'h80000000;
      if (c == 7) x[30:23] = 8'd0;
      if (c == 8) y[30:23] = 8'd0;
      if (c == 9) begin
        x[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 1) x[22:0] = '0;
      end
      if (c == 10) begin
        x[30:23] = 8'hFE;
        y[30:23] = 8'hFE;
      end
      if (c == 11) begin
        x[30:23] = 8'($urandom_range(0, 2));
        y[30:23] = 8'($urandom_range(0, 2));
      end
      sub = 1'($urandom);
      rm = 3'($urandom);
      model(x, y, sub, rm, mz, mf);
      run_check($sformatf("rand%0d x=%h y=%h sub=%0d rm=%0d", n, x, y, sub, rm), x, y, sub, rm, mz, mf,
                (&x[30:23] || &y[30:23]) ? 1 : 5);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
